// File: rtl/seq_det_1011.sv
// seq_det_1011: Mealy serial pattern detector (default 1011, overlapping); define SEQ_DET_CNT_EN to add a saturating match counter
module seq_det_1011 #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             out
);
  localparam int SW = $clog2(PAT_LEN);
  if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad
    $error("seq_det_1011: parameter out of range");
  end
  function automatic int nxt(input int s, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic hb;
    best = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          idx = s + 1 - k + j;
          hb  = (idx < s) ? PATTERN[PAT_LEN-1-idx] : b;
          if (PATTERN[PAT_LEN-1-j] != hb) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    if (!OVERLAP && s == PAT_LEN - 1 && b == PATTERN[0]) best = 0;
    return best;
  endfunction
  logic [SW-1:0] st;
  logic [SW-1:0] nst;
  logic [SW-1:0] nt0 [PAT_LEN];
  logic [SW-1:0] nt1 [PAT_LEN];
  for (genvar g = 0; g < PAT_LEN; g++) begin : g_tab
    assign nt0[g] = SW'(nxt(g, 1'b0));
    assign nt1[g] = SW'(nxt(g, 1'b1));
  end
  assign nst = in ? nt1[st] : nt0[st];
  assign out = (st == SW'(PAT_LEN - 1)) && (in == PATTERN[0]) && rst;
  // advance through the prefix automaton one received bit per clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= '0;
    else      st <= nst;
  end
`ifdef SEQ_DET_CNT_EN
  // count matches, holding at all-ones once full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      match_cnt <= '0;
    else if (out && ~&match_cnt)   match_cnt <= match_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_seq_det_1011.sv
// tb_seq_det_1011: directed checks of overlapping, non-overlapping and small-counter detector instances
module tb_seq_det_1011;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out_ov, out_no, out_sat;
  int   pass  = 0;
  int   total = 0;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;
`endif
  always #5 clk = ~clk;
  seq_det_1011 u_ov (
    .clk(clk), .rst(rst), .in(in),
`ifdef SEQ_DET_CNT_EN
    .match_cnt(cnt_ov),
`endif
    .out(out_ov)
  );
  seq_det_1011 #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .in(in),
`ifdef SEQ_DET_CNT_EN
    .match_cnt(cnt_no),
`endif
    .out(out_no)
  );
  seq_det_1011 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(in),
`ifdef SEQ_DET_CNT_EN
    .match_cnt(cnt_sat),
`endif
    .out(out_sat)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input string tag, input logic b, input logic eo, input logic en);
    @(negedge clk);
    in = b;
    #1;
    chk({tag, " out_ov"}, 32'(out_ov), 32'(eo));
    chk({tag, " out_no"}, 32'(out_no), 32'(en));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in  = 1'b0;
  endtask
  initial begin
    logic [9:0] s1;
    logic [9:0] e1o;
    logic [9:0] e1n;
    logic [5:0] s2;
    logic [5:0] e2;
    logic [3:0] fr;
    logic [1:0] sat_exp [5];
    s1  = 10'b1011011011;
    e1o = 10'b0001001001;
    e1n = 10'b0001000001;
    s2  = 6'b101011;
    e2  = 6'b000001;
    fr  = 4'b1011;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = i[0] ? 1'b0 : 1'b1;
      #1;
      chk("rst_hold out_ov", 32'(out_ov), 0);
      chk("rst_hold out_no", 32'(out_no), 0);
      chk("rst_hold st", 32'(u_ov.st), 0);
`ifdef SEQ_DET_CNT_EN
      chk("rst_hold cnt", 32'(cnt_ov), 0);
`endif
    end
    @(negedge clk);
    rst = 1'b1;
    in  = 1'b0;
    for (int i = 0; i < 10; i++) step($sformatf("stream bit%0d", i + 1), s1[9-i], e1o[9-i], e1n[9-i]);
    @(posedge clk);
    #1;
    chk("stream st_ov", 32'(u_ov.st), 1);
    chk("stream st_no", 32'(u_no.st), 0);
`ifdef SEQ_DET_CNT_EN
    chk("stream cnt_ov", 32'(cnt_ov), 3);
    chk("stream cnt_no", 32'(cnt_no), 2);
`endif
    do_reset();
    for (int i = 0; i < 6; i++) step($sformatf("fallback bit%0d", i + 1), s2[5-i], e2[5-i], e2[5-i]);
    do_reset();
    step("mid bit1", 1'b1, 1'b0, 1'b0);
    step("mid bit2", 1'b0, 1'b0, 1'b0);
    step("mid bit3", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in  = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid async st", 32'(u_ov.st), 0);
    chk("mid in_rst out_ov", 32'(out_ov), 0);
    chk("mid in_rst out_no", 32'(out_no), 0);
    @(negedge clk);
    rst = 1'b1;
    in  = 1'b1;
    #1;
    chk("mid post out_ov", 32'(out_ov), 0);
    @(posedge clk);
    #1;
    chk("mid post st", 32'(u_ov.st), 1);
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        in = fr[3-i];
        #1;
        chk($sformatf("sat f%0d b%0d out", f, i), 32'(out_sat), (i == 3) ? 1 : 0);
      end
      @(posedge clk);
      #1;
`ifdef SEQ_DET_CNT_EN
      chk($sformatf("sat f%0d cnt", f), 32'(cnt_sat), 32'(sat_exp[f]));
`else
      chk($sformatf("sat f%0d st", f), 32'(u_sat.st), 1);
`endif
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
